interp_sequencer: RTL and testbench
===================================

// Module: interp_sequencer
//
// PURPOSE
//  Frame-level controller for the subpixel interpolation datapath. It streams ROWS reference
//  rows into the input shift register, then issues OUT_WORDS filter operations. It captures
//  each filter result into the output filler after the filter pipeline latency, and signals done.
//  Sits between the row-fetch source and the input_shift_reg / filter / output_filler chain.
//
// PARAMETERS
//  ROWS       15  reference rows loaded per block (depth of the input shift register)
//  OUT_WORDS  40  filter results captured per block (output filler depth, 64-bit words)
//  FILT_LAT   2   cycles from filt_issue to a valid filter result (0 allowed)
//  SEL_W      8   width of out_sel / internal word counter
//
// PORTS
//  clock       in   1      single clock; all state updates on posedge
//  reset_L     in   1      synchronous, active-low reset
//  start       in   1      begin one block; sampled only in IDLE
//  abort       in   1      cancel current block; returns to IDLE next cycle
//  row_valid   in   1      source has a 120-bit row on the datapath input bus
//  row_ready   out  1      sequencer accepts a row this cycle
//  in_load_L   out  1      active-low load to input shift register
//  filt_issue  out  1      filter stage starts an operation this cycle
//  out_load_L  out  1      active-low load to output filler
//  out_sel     out  SEL_W  index of the result word being captured
//  busy        out  1      high in any state except IDLE
//  done        out  1      one-cycle pulse when a block completes normally
//  blk_cnt     out  16     completed-block counter; wraps 0xFFFF -> 0
//
// BEHAVIOUR
//  Reset (reset_L=0 at posedge): state=IDLE, counters and delay line cleared.
//   Outputs: row_ready=0, in_load_L=1, filt_issue=0, out_load_L=1, out_sel=0, busy=0,
//   done=0, blk_cnt=0.
//  States: IDLE -> FILL -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 & abort=0 -> FILL, row_cnt=0. Ignore start in all other states.
//  FILL: row_ready=1. in_load_L = ~row_valid, combinational in the same cycle. The datapath
//   registers sample on negedge, so the half-cycle is sufficient. row_cnt increments per
//   accepted row. Accept number ROWS -> ISSUE, word_cnt=0. No timeout; row_valid gaps stall.
//  ISSUE: filt_issue=1 each cycle, word_cnt 0..OUT_WORDS-1. {issue,word_cnt} enters the delay line.
//   After word OUT_WORDS-1 -> DRAIN. DRAIN lasts FILT_LAT cycles; skip it if FILT_LAT=0.
//  Delay line: FILT_LAT-stage register chain. out_load_L = ~tail_valid; out_sel = tail_sel.
//   When tail_valid=0, out_sel holds its last value.
//  DONE: done=1 for exactly one cycle, blk_cnt+1, -> IDLE. busy deasserts in IDLE.
//  Load counts per block: exactly ROWS in_load_L lows and exactly OUT_WORDS out_load_L lows,
//   with out_sel strictly 0,1,..,OUT_WORDS-1 in order.
//  abort=1 in any state: next cycle IDLE, delay line flushed (no further out_load_L), done stays 0,
//   blk_cnt unchanged. Same-cycle load strobes still follow the current state.
//   abort & start together in IDLE: abort wins, stay IDLE.
//  reset_L=0 mid-block: same as reset; no partial done.
//  Counters are sized for ROWS, OUT_WORDS <= 2**SEL_W-1. Elaboration error otherwise.
//
// STRUCTURE
//  interp_defs.vh: state encodings (localparam IDLE=0, FILL=1, ISSUE=2, DRAIN=3, DONE=4),
//   default ROWS/OUT_WORDS. Shared with the datapath top.
//  Sub-module interp_delay_line (WIDTH, DEPTH; sync active-low clear; DEPTH=0 = wire).
//   Carries {valid,sel}.
//  Top: FSM + row_cnt + word_cnt + drain_cnt + blk_cnt.
//
// TESTING
//  1 Reset, start, row_valid=1 continuously -> 15 consecutive in_load_L lows, then 40 filt_issue.
//   out_load_L low cycles 2..41 after first issue, out_sel 0..39, done 1 cycle, blk_cnt=1.
//  2 row_valid toggled 1/0 -> still exactly 15 loads. ISSUE entered the cycle after the 15th accept.
//  3 abort during ISSUE at word 20 -> IDLE next cycle, no out_load_L after flush, done=0, blk_cnt=0.
//  4 start held high through a block -> a second block starts only after done, from IDLE.
//   start & abort together in IDLE -> stays IDLE.
//  5 FILT_LAT=0 build -> out_load_L coincides with filt_issue. No DRAIN cycle; done follows the last issue.
//  6 reset_L=0 for 1 cycle mid-FILL -> all outputs at reset values next cycle. Preload blk_cnt=0xFFFF
//   via force, then complete a block -> blk_cnt=0.

Source files
------------

// File: rtl/interp_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// interp_sequencer_pkg
//   Shared definitions for the subpixel interpolation sequencer: FSM state
//   encodings (kept numerically identical to the datapath-side encodings),
//   default block geometry and a small counter helper.
// ---------------------------------------------------------------------------
package interp_sequencer_pkg;

  // Default block geometry
  localparam int ROWS_DEFAULT      = 15;  // reference rows per block
  localparam int OUT_WORDS_DEFAULT = 40;  // 64-bit result words per block
  localparam int FILT_LAT_DEFAULT  = 2;   // filter issue-to-result latency
  localparam int SEL_W_DEFAULT     = 8;   // width of out_sel / word counter
  localparam int BLK_W             = 16;  // completed-block counter width

  // Sequencer states; encodings are visible to the datapath top
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Block counter increment; wraps from all-ones back to zero
  function automatic logic [BLK_W-1:0] blk_next(input logic [BLK_W-1:0] cnt);
    return cnt + 16'd1;
  endfunction

endpackage

// File: rtl/interp_delay_line.sv
// ---------------------------------------------------------------------------
// interp_delay_line
//   DEPTH-stage register chain that models the filter pipeline latency for
//   the {valid, sel} tag travelling alongside each filter operation.
//   DEPTH = 0 degenerates to a plain wire.
//
// Ports
//   clock    in   1      posedge clock
//   clear_L  in   1      synchronous active-low clear of every stage
//   din      in   WIDTH  tag entering the chain this cycle
//   dout     out  WIDTH  tag leaving the chain (tail of the chain)
// ---------------------------------------------------------------------------
module interp_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             clear_L,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // Zero latency: the tail is the head; clock and clear have no role
    logic unused_s;
    assign unused_s = clock ^ clear_L;
    assign dout     = din;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register: clear flushes all in-flight tags at once
    always_ff @(posedge clock) begin
      if (!clear_L) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= {WIDTH{1'b0}};
        end
      end else begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/interp_sequencer.sv
// ---------------------------------------------------------------------------
// interp_sequencer
//   Frame-level controller for the subpixel interpolation datapath. Per block
//   it loads ROWS reference rows into the input shift register, issues
//   OUT_WORDS filter operations, captures each result into the output filler
//   FILT_LAT cycles after its issue, and pulses done.
//
// Ports
//   clock       in   1      single clock, posedge
//   reset_L     in   1      synchronous active-low reset
//   start       in   1      begin one block (sampled only in IDLE)
//   abort       in   1      cancel current block, IDLE next cycle
//   row_valid   in   1      source presents a row on the datapath bus
//   row_ready   out  1      sequencer accepts rows this cycle (FILL)
//   in_load_L   out  1      active-low load strobe to input shift register
//   filt_issue  out  1      filter starts an operation this cycle
//   out_load_L  out  1      active-low load strobe to output filler
//   out_sel     out  SEL_W  index of result word being captured
//   busy        out  1      high in every state except IDLE
//   done        out  1      one-cycle pulse on normal block completion
//   blk_cnt     out  16     completed-block counter, wraps to 0
// ---------------------------------------------------------------------------
module interp_sequencer
  import interp_sequencer_pkg::*;
#(
  parameter int ROWS      = ROWS_DEFAULT,
  parameter int OUT_WORDS = OUT_WORDS_DEFAULT,
  parameter int FILT_LAT  = FILT_LAT_DEFAULT,
  parameter int SEL_W     = SEL_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic             abort,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             in_load_L,
  output logic             filt_issue,
  output logic             out_load_L,
  output logic [SEL_W-1:0] out_sel,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] blk_cnt
);

  // Largest value an SEL_W counter can hold
  localparam int unsigned SEL_MAX = (32'd1 << SEL_W) - 32'd1;

  if (ROWS < 1 || ROWS > int'(SEL_MAX) ||
      OUT_WORDS < 1 || OUT_WORDS > int'(SEL_MAX) ||
      FILT_LAT < 0 || FILT_LAT > int'(SEL_MAX)) begin : g_bad_params
    $error("interp_sequencer: ROWS/OUT_WORDS/FILT_LAT do not fit SEL_W counters");
  end

  // Terminal counts; DRAIN_LAST is unused when there is no drain phase
  localparam logic [SEL_W-1:0] ROW_LAST   = SEL_W'(ROWS - 1);
  localparam logic [SEL_W-1:0] WORD_LAST  = SEL_W'(OUT_WORDS - 1);
  localparam logic [SEL_W-1:0] DRAIN_LAST = SEL_W'((FILT_LAT > 0) ? (FILT_LAT - 1) : 0);

  state_t           state_r, state_s;
  logic [SEL_W-1:0] row_cnt_r, row_cnt_s;
  logic [SEL_W-1:0] word_cnt_r, word_cnt_s;
  logic [SEL_W-1:0] drain_cnt_r, drain_cnt_s;
  logic [BLK_W-1:0] blk_cnt_r, blk_cnt_s;
  logic [SEL_W-1:0] sel_hold_r;

  logic             fill_s;
  logic             issue_s;
  logic             accept_s;
  logic             dl_clear_L_s;
  logic [SEL_W:0]   dl_in_s;
  logic [SEL_W:0]   dl_out_s;
  logic             tail_valid_s;
  logic [SEL_W-1:0] tail_sel_s;

  assign fill_s   = (state_r == ST_FILL);
  assign issue_s  = (state_r == ST_ISSUE);
  assign accept_s = fill_s & row_valid;

  // Abort flushes in-flight results so nothing reaches the filler afterwards
  assign dl_clear_L_s = reset_L & ~abort;
  assign dl_in_s      = {issue_s, word_cnt_r};

  interp_delay_line #(
    .WIDTH (SEL_W + 1),
    .DEPTH (FILT_LAT)
  ) u_delay_line (
    .clock   (clock),
    .clear_L (dl_clear_L_s),
    .din     (dl_in_s),
    .dout    (dl_out_s)
  );

  assign tail_valid_s = dl_out_s[SEL_W];
  assign tail_sel_s   = dl_out_s[SEL_W-1:0];

  // Next-state and counter update logic
  always_comb begin
    state_s     = state_r;
    row_cnt_s   = row_cnt_r;
    word_cnt_s  = word_cnt_r;
    drain_cnt_s = drain_cnt_r;
    blk_cnt_s   = blk_cnt_r;

    if (abort) begin
      // Abort wins over everything, including start in IDLE
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s   = ST_FILL;
            row_cnt_s = {SEL_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_FILL: begin
          // Gaps in row_valid simply stall; there is no timeout
          if (accept_s) begin
            if (row_cnt_r == ROW_LAST) begin
              state_s    = ST_ISSUE;
              word_cnt_s = {SEL_W{1'b0}};
            end else begin
              row_cnt_s = row_cnt_r + {{(SEL_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = ST_FILL;
          end
        end

        ST_ISSUE: begin
          if (word_cnt_r == WORD_LAST) begin
            // With zero latency the last result is captured this very cycle
            state_s     = (FILT_LAT == 0) ? ST_DONE : ST_DRAIN;
            drain_cnt_s = {SEL_W{1'b0}};
          end else begin
            word_cnt_s = word_cnt_r + {{(SEL_W-1){1'b0}}, 1'b1};
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_s = ST_DONE;
          end else begin
            drain_cnt_s = drain_cnt_r + {{(SEL_W-1){1'b0}}, 1'b1};
          end
        end

        ST_DONE: begin
          state_s   = ST_IDLE;
          blk_cnt_s = blk_next(blk_cnt_r);
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_r     <= ST_IDLE;
      row_cnt_r   <= {SEL_W{1'b0}};
      word_cnt_r  <= {SEL_W{1'b0}};
      drain_cnt_r <= {SEL_W{1'b0}};
      blk_cnt_r   <= {BLK_W{1'b0}};
    end else begin
      state_r     <= state_s;
      row_cnt_r   <= row_cnt_s;
      word_cnt_r  <= word_cnt_s;
      drain_cnt_r <= drain_cnt_s;
      blk_cnt_r   <= blk_cnt_s;
    end
  end

  // Remember the last captured word so out_sel is stable between captures
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      sel_hold_r <= {SEL_W{1'b0}};
    end else if (tail_valid_s) begin
      sel_hold_r <= tail_sel_s;
    end else begin
      sel_hold_r <= sel_hold_r;
    end
  end

  // in_load_L is combinational from row_valid: the datapath samples on the
  // falling edge, so the half-cycle settling time is sufficient.
  assign row_ready  = fill_s;
  assign in_load_L  = ~accept_s;
  assign filt_issue = issue_s;
  assign out_load_L = ~tail_valid_s;
  assign out_sel    = tail_valid_s ? tail_sel_s : sel_hold_r;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign blk_cnt    = blk_cnt_r;

endmodule

// File: tb/tb_interp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interp_sequencer
//   Directed bench for interp_sequencer. Two instances: dut (FILT_LAT=2) and
//   zdut (FILT_LAT=0). Stimulus pushes the expected {out_sel, cycle} of every
//   result capture into a per-instance queue; monitors pop and compare on
//   each out_load_L low, sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_interp_sequencer;

  localparam int SEL_W = 8;
  localparam int NW    = 40;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_L, start, abort, row_valid, z_start;

  logic             row_ready, in_load_L, filt_issue, out_load_L, busy, done;
  logic [SEL_W-1:0] out_sel;
  logic [15:0]      blk_cnt;

  logic             z_row_ready, z_in_load_L, z_filt_issue, z_out_load_L, z_busy, z_done;
  logic [SEL_W-1:0] z_out_sel;
  logic [15:0]      z_blk_cnt;

  interp_sequencer #(.ROWS(15), .OUT_WORDS(NW), .FILT_LAT(2), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .abort(abort),
    .row_valid(row_valid), .row_ready(row_ready), .in_load_L(in_load_L),
    .filt_issue(filt_issue), .out_load_L(out_load_L), .out_sel(out_sel),
    .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  interp_sequencer #(.ROWS(15), .OUT_WORDS(NW), .FILT_LAT(0), .SEL_W(SEL_W)) zdut (
    .clock(clock), .reset_L(reset_L), .start(z_start), .abort(abort),
    .row_valid(row_valid), .row_ready(z_row_ready), .in_load_L(z_in_load_L),
    .filt_issue(z_filt_issue), .out_load_L(z_out_load_L), .out_sel(z_out_sel),
    .busy(z_busy), .done(z_done), .blk_cnt(z_blk_cnt)
  );

  typedef struct {
    int sel;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t z_exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // main-instance monitor records
  int   in_loads = 0, issues = 0, dones = 0;
  int   first_load_cyc = 0, last_load_cyc = 0, first_issue_cyc = 0, done_cyc = 0;
  logic prev_load_L = 1'b1, prev_issue = 1'b0;
  // zero-latency instance monitor records
  int   z_dones = 0, z_first_issue_cyc = 0, z_done_cyc = 0;
  logic z_prev_issue = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_words(input bit to_z, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (to_z) z_exp_q.push_back('{i, first + i});
      else      exp_q.push_back('{i, first + i});
    end
  endtask

  // Main-instance monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_L) begin
        if (!in_load_L) begin
          in_loads++;
          if (prev_load_L) first_load_cyc = cyc;
          last_load_cyc = cyc;
        end
        if (filt_issue) begin
          issues++;
          if (!prev_issue) first_issue_cyc = cyc;
        end
        if (done) begin
          dones++;
          done_cyc = cyc;
        end
        if (!out_load_L) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL main_unexpected_capture actual_sel=%0d required=none (cycle %0d)", out_sel, cyc);
          end else begin
            e = exp_q.pop_front();
            check("main_out_sel", out_sel, e.sel);
            check("main_capture_cycle", cyc, e.cyc);
          end
        end
      end
      prev_load_L = in_load_L;
      prev_issue  = filt_issue;
    end
  end

  // Zero-latency instance monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_L) begin
        if (z_filt_issue && !z_prev_issue) z_first_issue_cyc = cyc;
        if (z_done) begin
          z_dones++;
          z_done_cyc = cyc;
        end
        if (!z_out_load_L) begin
          check("z_load_with_issue", z_filt_issue, 1);
          if (z_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL z_unexpected_capture actual_sel=%0d required=none (cycle %0d)", z_out_sel, cyc);
          end else begin
            e = z_exp_q.pop_front();
            check("z_out_sel", z_out_sel, e.sel);
            check("z_capture_cycle", cyc, e.cyc);
          end
        end
      end
      z_prev_issue = z_filt_issue;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_ready"},  row_ready,  0);
    check({tag, "_in_load_L"},  in_load_L,  1);
    check({tag, "_filt_issue"}, filt_issue, 0);
    check({tag, "_out_load_L"}, out_load_L, 1);
    check({tag, "_out_sel"},    out_sel,    0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_blk_cnt"},    blk_cnt,    0);
  endtask

  initial begin
    int s, l0, i0, d0, zd0;
    reset_L = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b0; z_start = 1'b0;
    step_n(3);
    check_reset_outputs("reset");
    reset_L = 1'b1;
    step();

    // 1: continuous rows, full block
    s = cyc; l0 = in_loads; i0 = issues; d0 = dones;
    start = 1'b1; row_valid = 1'b1;
    push_words(1'b0, s + 18, NW);
    step(); start = 1'b0;
    step_n(59);
    check("t1_loads", in_loads - l0, 15);
    check("t1_first_load", first_load_cyc, s + 1);
    check("t1_loads_consecutive", last_load_cyc - first_load_cyc, 14);
    check("t1_issues", issues - i0, NW);
    check("t1_first_issue", first_issue_cyc, s + 16);
    check("t1_done_count", dones - d0, 1);
    check("t1_done_cycle", done_cyc, s + 58);
    check("t1_blk_cnt", blk_cnt, 1);
    check("t1_busy_idle", busy, 0);

    // 2: row_valid toggling 1/0 still gives exactly 15 loads
    s = cyc; l0 = in_loads;
    start = 1'b1; row_valid = 1'b1;
    push_words(1'b0, s + 32, NW);
    for (int k = 1; k <= 29; k++) begin
      step();
      start = 1'b0;
      row_valid = k[0];
    end
    row_valid = 1'b1;
    check("t2_issue_not_early", filt_issue, 0);
    step();
    check("t2_issue_after_15th", filt_issue, 1);
    step_n(44);
    check("t2_loads", in_loads - l0, 15);
    check("t2_first_issue", first_issue_cyc, s + 30);
    check("t2_done_cycle", done_cyc, s + 72);
    check("t2_blk_cnt", blk_cnt, 2);

    // 3: abort during ISSUE at word 20
    s = cyc; i0 = issues; d0 = dones;
    start = 1'b1;
    push_words(1'b0, s + 18, 19);
    step(); start = 1'b0;
    step_n(35);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_busy_after_abort", busy, 0);
    check("t3_out_load_flushed", out_load_L, 1);
    step_n(10);
    check("t3_issues", issues - i0, 21);
    check("t3_no_done", dones - d0, 0);
    check("t3_blk_cnt", blk_cnt, 2);

    // 4: start held high; second block only after done, from IDLE
    s = cyc; d0 = dones;
    start = 1'b1;
    push_words(1'b0, s + 18, NW);
    push_words(1'b0, s + 77, NW);
    step_n(59);
    check("t4_idle_between", busy, 0);
    step();
    check("t4_restart_busy", busy, 1);
    start = 1'b0;
    step_n(60);
    check("t4_done_count", dones - d0, 2);
    check("t4_second_done", done_cyc, s + 117);
    check("t4_second_first_load", first_load_cyc, s + 60);
    check("t4_blk_cnt", blk_cnt, 4);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t4_abort_wins", busy, 0);
    step();
    check("t4_still_idle", busy, 0);

    // 5: zero-latency instance
    s = cyc; zd0 = z_dones;
    z_start = 1'b1;
    push_words(1'b1, s + 16, NW);
    step(); z_start = 1'b0;
    step_n(57);
    check("t5_first_issue", z_first_issue_cyc, s + 16);
    check("t5_done_count", z_dones - zd0, 1);
    check("t5_done_cycle", z_done_cyc, s + 56);
    check("t5_blk_cnt", z_blk_cnt, 1);
    check("t5_busy_idle", z_busy, 0);

    // 6: reset mid-FILL, then block counter wrap
    s = cyc;
    start = 1'b1; row_valid = 1'b1;
    step(); start = 1'b0;
    step_n(4);
    check("t6_in_fill", row_ready, 1);
    reset_L = 1'b0;
    step();
    check_reset_outputs("t6_reset");
    reset_L = 1'b1;
    force dut.blk_cnt_r = 16'hFFFF;
    #1;
    release dut.blk_cnt_r;
    step();
    check("t6_preload", blk_cnt, 16'hFFFF);
    s = cyc;
    start = 1'b1;
    push_words(1'b0, s + 18, NW);
    step(); start = 1'b0;
    step_n(59);
    check("t6_done_cycle", done_cyc, s + 58);
    check("t6_blk_wrap", blk_cnt, 0);

    step_n(4);
    check("main_queue_empty", exp_q.size(), 0);
    check("z_queue_empty", z_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
